// File: rtl/gate_chk_pkg.sv
//------------------------------------------------------------------------------
// Module   : gate_chk_pkg
// Purpose  : Shared types and constants for the gate sweep checker.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package gate_chk_pkg;

   localparam int c_settle_cnt_w = 8;
   localparam int c_n_in_max     = 6;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT   = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } gate_chk_state_e;

endpackage

`default_nettype wire

// File: rtl/gate_sweep_checker_if.sv
//------------------------------------------------------------------------------
// Module   : gate_sweep_checker_if
// Purpose  : Control, truth-table, gate stimulus/response and result bundle.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface gate_sweep_checker_if #(
   parameter int N_IN = 2
);
   logic                 start;
   logic [2**N_IN-1:0]   exp_tt;
   logic                 resp;
   logic [N_IN-1:0]      stim;
   logic                 busy;
   logic                 done;
   logic                 pass;
   logic [N_IN:0]        err_cnt;
   logic                 fail_vld;
   logic [N_IN-1:0]      fail_idx;

   // master: environment side (requests sweeps, carries the gate output back)
   modport master (
      output start, exp_tt, resp,
      input  stim, busy, done, pass, err_cnt, fail_vld, fail_idx
   );

   modport slave (
      input  start, exp_tt, resp,
      output stim, busy, done, pass, err_cnt, fail_vld, fail_idx
   );
endinterface

`default_nettype wire

// File: rtl/gate_chk_settle_cnt.sv
//------------------------------------------------------------------------------
// Module   : gate_chk_settle_cnt
// Purpose  : Loadable 8-bit down-counter with zero flag for vector settling.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module gate_chk_settle_cnt
   import gate_chk_pkg::*;
(
   input  wire logic                      clk,
   input  wire logic                      rst_n,
   input  wire logic                      load,
   input  wire logic [c_settle_cnt_w-1:0] load_val,
   input  wire logic                      dec,
   output logic                           zero
);

   logic [c_settle_cnt_w-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (load) begin
         r_cnt <= load_val;
      end else if (dec && (r_cnt != '0)) begin
         r_cnt <= r_cnt - c_settle_cnt_w'(1);
      end
   end

   assign zero = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/gate_sweep_checker.sv
//------------------------------------------------------------------------------
// Module   : gate_sweep_checker
// Purpose  : Drives every input vector of an N_IN-input gate, samples its
//            output after SETTLE cycles and checks it against exp_tt.
//            Option: GATE_CHK_STOP_ON_FAIL_EN ends the sweep on first mismatch.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module gate_sweep_checker
   import gate_chk_pkg::*;
#(
   parameter int N_IN   = 2,
   parameter int SETTLE = 1
) (
   input  wire logic            clk,
   input  wire logic            rst_n,
   gate_sweep_checker_if.slave  bus
);

   localparam logic [c_settle_cnt_w-1:0] c_settle_ld = c_settle_cnt_w'(SETTLE - 1);
   localparam logic [N_IN-1:0]           c_last_idx  = {N_IN{1'b1}};

   gate_chk_state_e      r_state;
   gate_chk_state_e      w_state_nxt;

   logic [2**N_IN-1:0]   r_tt;
   logic [N_IN-1:0]      r_idx;
   logic [N_IN:0]        r_err_cnt;
   logic                 r_fail_vld;
   logic [N_IN-1:0]      r_fail_idx;
   logic                 r_pass;

   logic                 w_cnt_load;
   logic                 w_cnt_dec;
   logic                 w_cnt_zero;
   logic                 w_accept;
   logic                 w_advance;
   logic                 w_finish;
   logic                 w_mismatch;
   logic [N_IN:0]        w_err_nxt;

   gate_chk_settle_cnt u_settle_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (w_cnt_load),
      .load_val (c_settle_ld),
      .dec      (w_cnt_dec),
      .zero     (w_cnt_zero)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_load  = 1'b0;
      w_cnt_dec   = 1'b0;
      w_accept    = 1'b0;
      w_advance   = 1'b0;
      w_finish    = 1'b0;
      w_mismatch  = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.start) begin
               w_accept    = 1'b1;
               w_cnt_load  = 1'b1;
               w_state_nxt = WAIT;
            end
         end
         WAIT: begin
            if (w_cnt_zero) begin
               w_state_nxt = SAMPLE;
            end else begin
               w_cnt_dec = 1'b1;
            end
         end
         SAMPLE: begin
            w_mismatch = (bus.resp != r_tt[r_idx]);
`ifdef GATE_CHK_STOP_ON_FAIL_EN
            w_finish   = (r_idx == c_last_idx) || w_mismatch;
`else
            w_finish   = (r_idx == c_last_idx);
`endif
            if (w_finish) begin
               w_state_nxt = DONE;
            end else begin
               w_advance   = 1'b1;
               w_cnt_load  = 1'b1;
               w_state_nxt = WAIT;
            end
         end
         DONE: begin
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   assign w_err_nxt = r_err_cnt + {{N_IN{1'b0}}, w_mismatch};

   // Results stay frozen outside SAMPLE so they remain readable until the next start.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tt       <= '0;
         r_idx      <= '0;
         r_err_cnt  <= '0;
         r_fail_vld <= 1'b0;
         r_fail_idx <= '0;
         r_pass     <= 1'b0;
      end else if (w_accept) begin
         r_tt       <= bus.exp_tt;
         r_idx      <= '0;
         r_err_cnt  <= '0;
         r_fail_vld <= 1'b0;
         r_fail_idx <= '0;
         r_pass     <= 1'b0;
      end else if (r_state == SAMPLE) begin
         r_err_cnt <= w_err_nxt;
         if (w_mismatch && !r_fail_vld) begin
            r_fail_vld <= 1'b1;
            r_fail_idx <= r_idx;
         end
         if (w_advance) begin
            r_idx <= r_idx + N_IN'(1);
         end
         if (w_finish) begin
            r_pass <= (w_err_nxt == '0);
         end
      end
   end

   assign bus.stim     = r_idx;
   assign bus.busy     = (r_state == WAIT) || (r_state == SAMPLE);
   assign bus.done     = (r_state == DONE);
   assign bus.pass     = r_pass;
   assign bus.err_cnt  = r_err_cnt;
   assign bus.fail_vld = r_fail_vld;
   assign bus.fail_idx = r_fail_idx;

endmodule

`default_nettype wire
